servo_scheduler: RTL and testbench
==================================

# servo_scheduler

Time-division servo controller that drives N_CH hobby-servo outputs from one shared microsecond timebase. Each 20 ms frame is split into N_CH equal slots; channel k emits its pulse at the start of slot k. A valid/ready write port updates pulse widths into pending registers, which commit to the active set only at a frame boundary, so every frame is coherent. It sits between the CPU/register bridge and the servo pins, replacing one free-running timer per servo.

## Interface
- CLK_F, 25: clock frequency in MHz; prescaler divides to a 1 µs tick.
- N_CH, 8: number of channels, 1..16.
- SLOT_US, 2500: slot length in µs; frame = N_CH*SLOT_US (20000 at defaults).
- MIN_US, 500: lower clamp for nonzero widths.
- MAX_US, 2500: upper clamp; must satisfy MIN_US <= MAX_US <= SLOT_US.
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  run scheduler; low holds timebase and forces outputs low.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_ch  in  max(1,$clog2(N_CH))  target channel.
- wr_pulse  in  16  requested pulse width, µs; 0 = channel off.
- control  out  N_CH  servo pulse outputs, registered.
- frame_start  out  1  one-cycle strobe at each frame start.

## Operation
- Reset: prescaler, us_cnt, slot all 0; pending and active all 0; control = 0; frame_start = 0.
- Write: on accept, pending[wr_ch] <= clamp(wr_pulse). clamp: 0 -> 0; 1..MIN_US-1 -> MIN_US; > MAX_US -> MAX_US; else unchanged. wr_ch >= N_CH: accepted, dropped.
- Timebase (enable high): tick when prescaler == CLK_F-1, prescaler wraps to 0. On tick, us_cnt increments, wraps at SLOT_US-1 to 0 and advances slot; slot wraps at N_CH-1 to 0.
- Output: on each tick edge, control <= one-hot(slot) if us_cnt < active[slot], else 0 (us_cnt, slot sampled before increment). At most one bit of control high at any time.
- Commit edge: tick with slot == N_CH-1 and us_cnt == SLOT_US-1; active <= pending on that edge.
- wr_ready = 0 combinationally in the commit-edge cycle, 1 otherwise; a write can never race the commit.
- enable low: prescaler, us_cnt, slot held at 0; control <= 0; active <= pending every cycle; wr_ready = 1. Rising enable starts a fresh frame at slot 0 using the latest pending values.
- enable falling mid-pulse: control goes low next edge; no truncated-pulse recovery.
- resetn asserted mid-frame: all state to reset values immediately.

## Timing
- Tick period = CLK_F cycles. Active width L produces control[k] high for exactly L*CLK_F cycles; L = 0 gives no pulse; L = SLOT_US gives a high output for the whole slot.
- First rising edge of control[0] is CLK_F cycles after the first cycle enable is sampled high.
- Write latency: visible from the first frame that starts after acceptance; a value accepted in the cycle before commit applies to the next frame.
- frame_start: registered, high one cycle after each commit edge and one cycle after enable is first sampled high.
- Counter widths: prescaler $clog2(CLK_F), us_cnt $clog2(SLOT_US), slot $clog2(N_CH); comparison us_cnt < active uses 16-bit zero-extended us_cnt.

## Structure
- Package servo_pkg: CLK_F default, default frame length 20000 µs, MIN/MAX defaults, clamp function, pulse-width type (16-bit).
- Sub-module servo_tick_gen: prescaler, tick out, synchronous clear from enable, shared with other servo blocks.
- pending/active as register arrays (no RAM); output stage purely registered.

## Test plan
- CLK_F=4, N_CH=4, SLOT_US=50, MIN=10, MAX=40: write ch0=20, ch2=30, enable -> control[0] high 80 cycles from slot 0 start, control[2] high 120 cycles in slot 2, ch1/ch3 never high.
- Write 5 -> reads back as 10-µs pulse (40 cycles); write 1000 -> 40 µs (160 cycles); write 0 -> no pulse.
- Write ch0=30 mid-frame -> current frame keeps 20, next frame after frame_start uses 30.
- Hold wr_valid across commit edge -> wr_ready low exactly that cycle, write accepted next cycle, applied one frame later.
- Deassert enable during ch2 pulse -> control low next cycle; re-enable -> frame_start, control[0] rises after CLK_F cycles.
- Assert resetn low mid-pulse -> control and frame_start 0 immediately, prior writes lost (no pulses after re-enable until rewritten).

Source files
------------

// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - servo scheduler defaults, pulse-width type and clamp helper
package servo_pkg;

  localparam int CLK_F_DEF    = 25;
  localparam int N_CH_DEF     = 8;
  localparam int FRAME_US_DEF = 20000;
  localparam int MIN_US_DEF   = 500;
  localparam int MAX_US_DEF   = 2500;

  typedef logic [15:0] pulse_t;

  // Zero stays zero so a channel can be switched off; anything else is forced into range.
  function automatic pulse_t clamp_pulse(input pulse_t w, input pulse_t min_us,
                                         input pulse_t max_us);
    pulse_t r;
    r = w;
    if (w == '0)
      r = '0;
    else if (w < min_us)
      r = min_us;
    else if (w > max_us)
      r = max_us;
    return r;
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// rtl/servo_tick_gen.sv - 1 us tick prescaler, cleared while enable is low
module servo_tick_gen #(
  parameter int CLK_F = 25
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  output logic tick
);

  localparam int PW = (CLK_F > 1) ? $clog2(CLK_F) : 1;

  logic [PW-1:0] prescaler;

  assign tick = enable && (prescaler == PW'(CLK_F - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      prescaler <= '0;
    else if (!enable || tick)
      prescaler <= '0;
    else
      prescaler <= prescaler + 1'b1;
  end

endmodule

// File: rtl/servo_scheduler.sv
// rtl/servo_scheduler.sv - time-division servo pulse scheduler with frame-coherent updates
module servo_scheduler
  import servo_pkg::*;
#(
  parameter int CLK_F   = CLK_F_DEF,
  parameter int N_CH    = N_CH_DEF,
  parameter int SLOT_US = FRAME_US_DEF / N_CH_DEF,
  parameter int MIN_US  = MIN_US_DEF,
  parameter int MAX_US  = MAX_US_DEF,
  localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [CW-1:0]   wr_ch,
  input  logic [15:0]     wr_pulse,
  output logic [N_CH-1:0] control,
  output logic            frame_start
);

  localparam int UW = (SLOT_US > 1) ? $clog2(SLOT_US) : 1;

  logic            tick;
  logic [UW-1:0]   us_cnt;
  logic [CW-1:0]   slot;
  logic            slot_end;
  logic            commit;
  logic            enable_q;
  logic [N_CH-1:0] slot_hot;
  pulse_t          pending [N_CH];
  pulse_t          active  [N_CH];

  servo_tick_gen #(.CLK_F(CLK_F)) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .enable (enable),
    .tick   (tick)
  );

  assign slot_end = (us_cnt == UW'(SLOT_US - 1));
  assign commit   = tick && slot_end && (slot == CW'(N_CH - 1));
  // Blocking writes on the commit edge keeps a write from landing half in one frame.
  assign wr_ready = !commit;

  always_comb begin
    slot_hot       = '0;
    slot_hot[slot] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      us_cnt <= '0;
      slot   <= '0;
    end else if (!enable) begin
      us_cnt <= '0;
      slot   <= '0;
    end else if (tick) begin
      if (slot_end) begin
        us_cnt <= '0;
        slot   <= (slot == CW'(N_CH - 1)) ? '0 : slot + 1'b1;
      end else begin
        us_cnt <= us_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_CH; i++) begin
        pending[i] <= '0;
        active[i]  <= '0;
      end
    end else begin
      if (wr_valid && wr_ready && ({1'b0, wr_ch} < (CW + 1)'(N_CH)))
        pending[wr_ch] <= clamp_pulse(wr_pulse, 16'(MIN_US), 16'(MAX_US));
      if (!enable || commit)
        active <= pending;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      control     <= '0;
      frame_start <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      enable_q    <= enable;
      frame_start <= commit || (enable && !enable_q);
      if (!enable)
        control <= '0;
      else if (tick)
        control <= (16'(us_cnt) < active[slot]) ? slot_hot : '0;
    end
  end

endmodule

// File: tb/tb_servo_scheduler.sv
// tb/tb_servo_scheduler.sv - directed bench for servo_scheduler at CLK_F=4, N_CH=4, SLOT_US=50
module tb_servo_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_ch;
  logic [15:0] wr_pulse;
  logic [3:0]  control;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rises [4] = '{default: 0};
  int multi = 0;
  int fs_count = 0;
  logic [3:0] prev = '0;

  servo_scheduler #(
    .CLK_F(4), .N_CH(4), .SLOT_US(50), .MIN_US(10), .MAX_US(40)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_ch       (wr_ch),
    .wr_pulse    (wr_pulse),
    .control     (control),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (control[i] && !prev[i]) rises[i] <= rises[i] + 1;
    prev <= control;
    if (!$onehot0(control)) multi <= multi + 1;
    if (frame_start) fs_count <= fs_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [15:0] val, output int waits);
    logic acc;
    wr_valid = 1'b1;
    wr_ch    = ch;
    wr_pulse = val;
    waits    = 0;
    acc      = 1'b0;
    while (!acc && waits < 10) begin
      @(negedge clk);
      acc = wr_ready;
      step();
      if (!acc) waits++;
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_rise(input int ch, output int n);
    n = 0;
    while (!control[ch] && n < 2000) begin
      step();
      n++;
    end
  endtask

  task automatic measure(input int ch, output int n);
    n = 0;
    while (control[ch] && n < 2000) begin
      step();
      n++;
    end
  endtask

  initial begin
    int w, n, c0, fs0, snap;
    resetn   = 1'b0;
    enable   = 1'b0;
    wr_valid = 1'b0;
    wr_ch    = '0;
    wr_pulse = '0;
    steps(3);
    check("reset_control", 32'(control), 0);
    check("reset_frame_start", 32'(frame_start), 0);
    check("reset_wr_ready", 32'(wr_ready), 1);
    resetn = 1'b1;
    step();

    do_write(2'd0, 16'd20, w);
    check("wr0_waits", w, 0);
    do_write(2'd2, 16'd30, w);
    check("wr2_waits", w, 0);
    steps(2);

    // First frame: rise CLK_F-1 edges after the edge that samples enable.
    enable = 1'b1;
    step();
    check("en_frame_start", 32'(frame_start), 1);
    check("en_control_e0", 32'(control), 0);
    step();
    check("en_frame_start_low", 32'(frame_start), 0);
    step();
    check("en_control_e2", 32'(control), 0);
    step();
    check("ch0_first_rise", 32'(control), 32'd1);
    measure(0, n);
    check("ch0_width_20us", n, 80);
    wait_rise(2, n);
    check("ch2_rise_gap", n, 320);
    measure(2, n);
    check("ch2_width_30us", n, 120);
    check("ch1_never", rises[1], 0);
    check("ch3_never", rises[3], 0);

    // Clamping, applied from the next frame.
    do_write(2'd1, 16'd5, w);
    do_write(2'd3, 16'd1000, w);
    do_write(2'd2, 16'd0, w);
    check("clamp_wr_waits", w, 0);
    wait_rise(0, n);
    check("f1_ch0_rise", 32'(control[0]), 1);
    measure(0, n);
    check("f1_ch0_width", n, 80);
    do_write(2'd0, 16'd30, w);
    do_write(2'd2, 16'd30, w);
    wait_rise(1, n);
    check("f1_ch1_rise", 32'(control[1]), 1);
    measure(1, n);
    check("f1_ch1_clamp_min", n, 40);
    snap = rises[2];
    wait_rise(3, n);
    check("f1_ch3_rise", 32'(control[3]), 1);
    measure(3, n);
    check("f1_ch3_clamp_max", n, 160);
    check("f1_ch2_off", rises[2], snap);

    // Next frame picks up the mid-frame write to ch0.
    n = 0;
    while (!frame_start && n < 2000) begin
      step();
      n++;
    end
    check("f2_frame_start", 32'(frame_start), 1);
    c0 = cyc;
    wait_rise(0, n);
    check("f2_ch0_rise_gap", n, 4);
    measure(0, n);
    check("f2_ch0_width_30us", n, 120);

    // Write held across the commit edge.
    while (cyc < c0 + 798) step();
    check("ready_before_commit", 32'(wr_ready), 1);
    step();
    check("ready_commit_cycle", 32'(wr_ready), 0);
    fs0 = fs_count;
    do_write(2'd1, 16'd15, w);
    check("commit_write_waits", w, 1);
    check("commit_frame_start", fs_count, fs0 + 1);
    wait_rise(1, n);
    check("f3_ch1_rise", 32'(control[1]), 1);
    measure(1, n);
    check("f3_ch1_old_width", n, 40);
    wait_rise(1, n);
    check("f4_ch1_rise", 32'(control[1]), 1);
    measure(1, n);
    check("f4_ch1_new_width", n, 60);

    // Disable mid-pulse, then re-enable.
    wait_rise(2, n);
    steps(10);
    check("ch2_mid_pulse", 32'(control), 32'd4);
    enable = 1'b0;
    step();
    check("disable_control_low", 32'(control), 0);
    steps(3);
    check("disabled_ready", 32'(wr_ready), 1);
    check("disabled_frame_start", 32'(frame_start), 0);
    enable = 1'b1;
    step();
    check("reen_frame_start", 32'(frame_start), 1);
    check("reen_control_e0", 32'(control), 0);
    steps(2);
    check("reen_control_e2", 32'(control), 0);
    step();
    check("reen_ch0_rise", 32'(control), 32'd1);

    // Asynchronous reset mid-pulse wipes pending and active widths.
    steps(5);
    check("pre_reset_high", 32'(control), 32'd1);
    resetn = 1'b0;
    #1;
    check("async_reset_control", 32'(control), 0);
    check("async_reset_frame_start", 32'(frame_start), 0);
    steps(2);
    resetn = 1'b1;
    step();
    snap = rises[0] + rises[1] + rises[2] + rises[3];
    steps(900);
    check("post_reset_no_pulses", rises[0] + rises[1] + rises[2] + rises[3], snap);
    check("post_reset_control", 32'(control), 0);
    check("onehot_control", multi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
